// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver:
// segment bit positions, the hex glyph table and the segment vector type.
package seg_pkg;

  // Segment vector layout: {DP,G,F,E,D,C,B,A}
  typedef logic [7:0] seg_vec_t;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Glyphs for 0..F as {G,F,E,D,C,B,A}, active-high
  localparam logic [6:0] SEG_HEX_TABLE [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Frame-load handshake bundle for seg_scan_driver.
// master: data producer; slave: the display driver.
interface seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;

  modport master (
    output load_valid,
    output data_in,
    output dp_in,
    output blank_in,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  data_in,
    input  dp_in,
    input  blank_in,
    output load_ready
  );
endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational nibble + decimal point + blank to active-high segment vector.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output seg_vec_t   seg
);

  // Blank darkens the whole digit including DP
  always_comb begin
    seg = '0;
    if (!blank) begin
      seg[SEG_G:SEG_A] = SEG_HEX_TABLE[nibble];
      seg[SEG_DP]      = dp;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with hex decode, per-digit
// DP and blank, and frame-boundary (tear-free) data loading.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN suppresses leading zero
// digits (segments off, DP kept) when the display register is loaded.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  seg_scan_driver_if.slave    load_if,
  output logic [7:0]          seg_out,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame_tick
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]         pre_cnt;
  logic [IW-1:0]         idx;
  logic                  slot_tick;
  logic                  frame_wrap;
  logic                  load_accept;

  logic                  pend_valid;
  logic [4*DIGITS-1:0]   pend_data;
  logic [DIGITS-1:0]     pend_dp;
  logic [DIGITS-1:0]     pend_blank;

  logic [4*DIGITS-1:0]   disp_data;
  logic [DIGITS-1:0]     disp_dp;
  logic [DIGITS-1:0]     disp_blank;

  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_blank;
  seg_vec_t              dec_seg;
  seg_vec_t              cur_seg;

  seg_vec_t              seg_q;
  logic [DIGITS-1:0]     dig_q;
  logic                  wrap_q;
  logic                  frame_tick_q;

  assign slot_tick   = (pre_cnt == PW'(SCAN_DIV - 1));
  assign frame_wrap  = slot_tick && (idx == IW'(DIGITS - 1));
  assign load_accept = load_if.load_valid && !pend_valid;
  assign load_if.load_ready = !pend_valid;

  // Slot prescaler: counts 0..SCAN_DIV-1 and wraps
  always_ff @(posedge clk_in) begin
    if (rst_in)         pre_cnt <= '0;
    else if (slot_tick) pre_cnt <= '0;
    else                pre_cnt <= pre_cnt + 1'b1;
  end

  // Digit index: advances per slot, wraps at DIGITS-1
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx <= '0;
    end else if (slot_tick) begin
      if (idx == IW'(DIGITS - 1)) idx <= '0;
      else                        idx <= idx + 1'b1;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] sup_next;
  logic [DIGITS-1:0] disp_sup;
  logic              zero_run;

  // Leading-zero mask of the pending data: digit i is suppressed when it and
  // every digit above it are zero; digit 0 is never suppressed
  always_comb begin
    sup_next = '0;
    zero_run = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (pend_data[4*i +: 4] == 4'h0);
      sup_next[i] = zero_run;
    end
  end

  // Suppression mask travels with the display register
  always_ff @(posedge clk_in) begin
    if (rst_in)                        disp_sup <= '0;
    else if (frame_wrap && pend_valid) disp_sup <= sup_next;
  end
`endif

  // Pending and display registers: loads land in pending, move to the
  // display only at a frame boundary
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      disp_data  <= '0;
      disp_dp    <= '0;
      disp_blank <= '1;
    end else if (frame_wrap && pend_valid) begin
      disp_data  <= pend_data;
      disp_dp    <= pend_dp;
      disp_blank <= pend_blank;
      pend_valid <= 1'b0;
    end else if (load_accept) begin
      pend_data  <= load_if.data_in;
      pend_dp    <= load_if.dp_in;
      pend_blank <= load_if.blank_in;
      pend_valid <= 1'b1;
    end
  end

  // Select the currently scanned digit from the display register
  always_comb begin
    cur_nibble = disp_data[4*idx +: 4];
    cur_dp     = disp_dp[idx];
    cur_blank  = disp_blank[idx];
  end

  seg_hex_decoder u_dec (
    .nibble (cur_nibble),
    .dp     (cur_dp),
    .blank  (cur_blank),
    .seg    (dec_seg)
  );

  // Apply leading-zero suppression (segments only, DP preserved)
  always_comb begin
    cur_seg = dec_seg;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (disp_sup[idx]) cur_seg[SEG_G:SEG_A] = '0;
`endif
  end

  // Registered outputs; frame_tick is delayed twice so it lines up with the
  // first output cycle of digit 0, which itself lags the wrap edge by one
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      seg_q        <= '0;
      dig_q        <= '0;
      wrap_q       <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      seg_q        <= cur_seg;
      dig_q        <= DIGITS'(1) << idx;
      wrap_q       <= frame_wrap;
      frame_tick_q <= wrap_q;
    end
  end

  assign seg_out    = seg_q ^ {8{SEG_ACTIVE_LOW != 0}};
  assign dig_sel    = dig_q ^ {DIGITS{DIG_ACTIVE_LOW != 0}};
  assign frame_tick = frame_tick_q;

endmodule
